// File: rtl/reduction_pkg.sv
// reduction_pkg: op codes, entry states and the per-entry control record shared by the reduction engine
package reduction_pkg;
    localparam logic [3:0] OP_ADD  = 4'b1111;
    localparam logic [3:0] OP_MAX  = 4'b0000;
    localparam logic [3:0] OP_MIN  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_LAND = 4'b0100;
    localparam logic [3:0] OP_LOR  = 4'b0101;
    typedef enum logic [1:0] {ST_FREE, ST_ACCUM, ST_DONE} entry_state_e;
    // width-independent part of an entry; tag/dst/remaining/accumulator are parameter-sized arrays in the engine
    typedef struct packed {
        entry_state_e state;
        logic [3:0]   op;
    } entry_t;
    function automatic logic op_known(input logic [3:0] op);
        return op == OP_ADD || op <= OP_LOR;
    endfunction
endpackage

// File: rtl/reduce_alu.sv
// reduce_alu: combines accumulator and contribution, then delays result, entry index and valid by ALU_LAT stages
module reduce_alu
    import reduction_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 2,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_res,
    output logic              out_err
);
    logic [DATA_W-1:0] res;
    logic [ALU_LAT-1:0] v_q, err_q;
    logic [IDX_W-1:0] idx_q [ALU_LAT];
    logic [DATA_W-1:0] res_q [ALU_LAT];
    always_comb begin
        res = in_a;
        case (in_op)
            OP_ADD:  res = in_a + in_b;
            OP_MAX:  res = $signed(in_a) > $signed(in_b) ? in_a : in_b;
            OP_MIN:  res = $signed(in_a) < $signed(in_b) ? in_a : in_b;
            OP_AND:  res = in_a & in_b;
            OP_OR:   res = in_a | in_b;
            OP_LAND: res = DATA_W'(in_a != '0 && in_b != '0);
            OP_LOR:  res = DATA_W'(in_a != '0 || in_b != '0);
            default: res = in_a;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            err_q <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                idx_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            v_q[0] <= in_valid;
            err_q[0] <= in_valid && !op_known(in_op);
            idx_q[0] <= in_idx;
            res_q[0] <= res;
            for (int k = 1; k < ALU_LAT; k++) begin
                v_q[k] <= v_q[k-1];
                err_q[k] <= err_q[k-1];
                idx_q[k] <= idx_q[k-1];
                res_q[k] <= res_q[k-1];
            end
        end
    end
    assign out_valid = v_q[ALU_LAT-1];
    assign out_err = err_q[ALU_LAT-1];
    assign out_idx = idx_q[ALU_LAT-1];
    assign out_res = res_q[ALU_LAT-1];
endmodule

// File: rtl/reduction_engine.sv
// reduction_engine: tag-indexed table that folds tagged contributions through a pipelined ALU
// and emits one result per tag once all expected contributions have been combined
module reduction_engine
    import reduction_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 8,
    parameter int CHILD_W = 3,
    parameter int ALU_LAT = 2,
    parameter int DST_W   = 9,
    parameter logic [DST_W-1:0] RANK = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [3:0]                 in_op,
    input  logic [CHILD_W-1:0]         in_children,
    input  logic [DST_W-1:0]           in_dst,
    input  logic [DATA_W-1:0]          in_payload,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [3:0]                 out_op,
    output logic [DST_W-1:0]           out_src,
    output logic [DST_W-1:0]           out_dst,
    output logic [DATA_W-1:0]          out_payload,
    output logic                       err_op,
    output logic [$clog2(DEPTH):0]     busy_count
);
    localparam int IDX_W = $clog2(DEPTH);
    entry_t ent_q [DEPTH], ent_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH], tag_d [DEPTH];
    logic [DST_W-1:0] dst_q [DEPTH], dst_d [DEPTH];
    logic [CHILD_W-1:0] rem_q [DEPTH], rem_d [DEPTH];
    logic [DATA_W-1:0] acc_q [DEPTH], acc_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] idx, sel_idx, first_done, lock_idx_q, wb_idx;
    logic rdy_en_q, lock_q, any_done, accept, issue, out_fire, wb_valid, wb_err;
    logic [DATA_W-1:0] wb_res;
    entry_state_e tgt_st;

    assign idx = in_tag[IDX_W-1:0];
    assign tgt_st = ent_q[idx].state;
    assign in_ready = rdy_en_q && tgt_st != ST_DONE && !pend_q[idx] &&
                      !(tgt_st == ST_ACCUM && tag_q[idx] != in_tag);
    assign accept = in_valid && in_ready;
    assign issue = accept && tgt_st == ST_ACCUM;
    assign err_op = (issue && in_op != ent_q[idx].op) || wb_err;
    assign out_valid = any_done;
    assign out_fire = out_valid && out_ready;
    // a presented entry stays selected until taken, even if a lower index completes meanwhile
    assign sel_idx = lock_q ? lock_idx_q : first_done;
    assign out_tag = out_valid ? tag_q[sel_idx] : '0;
    assign out_op = out_valid ? ent_q[sel_idx].op : '0;
    assign out_src = out_valid ? RANK : '0;
    assign out_dst = out_valid ? dst_q[sel_idx] : '0;
    assign out_payload = out_valid ? acc_q[sel_idx] : '0;

    reduce_alu #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ALU_LAT(ALU_LAT)) u_alu (
        .clk(clk), .rst(rst), .in_valid(issue), .in_idx(idx), .in_op(ent_q[idx].op),
        .in_a(acc_q[idx]), .in_b(in_payload), .out_valid(wb_valid), .out_idx(wb_idx),
        .out_res(wb_res), .out_err(wb_err)
    );

    always_comb begin
        any_done = 1'b0;
        first_done = '0;
        busy_count = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].state == ST_DONE) begin
                any_done = 1'b1;
                first_done = IDX_W'(i);
            end
            if (ent_q[i].state != ST_FREE) busy_count = busy_count + 1'b1;
        end
    end

    // accept, writeback and output handshake never target the same entry, so their updates compose freely
    always_comb begin
        ent_d = ent_q;
        tag_d = tag_q;
        dst_d = dst_q;
        rem_d = rem_q;
        acc_d = acc_q;
        pend_d = pend_q;
        if (accept && tgt_st == ST_FREE) begin
            ent_d[idx].state = in_children == '0 ? ST_DONE : ST_ACCUM;
            ent_d[idx].op = in_op;
            tag_d[idx] = in_tag;
            dst_d[idx] = in_dst;
            rem_d[idx] = in_children;
            acc_d[idx] = in_payload;
        end
        if (issue) pend_d[idx] = 1'b1;
        if (wb_valid) begin
            acc_d[wb_idx] = wb_res;
            rem_d[wb_idx] = rem_q[wb_idx] - 1'b1;
            pend_d[wb_idx] = 1'b0;
            if (rem_q[wb_idx] == CHILD_W'(1)) ent_d[wb_idx].state = ST_DONE;
        end
        if (out_fire) ent_d[sel_idx].state = ST_FREE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '{ST_FREE, 4'h0};
                tag_q[i] <= '0;
                dst_q[i] <= '0;
                rem_q[i] <= '0;
                acc_q[i] <= '0;
            end
            pend_q <= '0;
            rdy_en_q <= 1'b0;
            lock_q <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ent_q <= ent_d;
            tag_q <= tag_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
            acc_q <= acc_d;
            pend_q <= pend_d;
            rdy_en_q <= 1'b1;
            lock_q <= out_valid && !out_ready;
            lock_idx_q <= sel_idx;
        end
    end
endmodule

// File: tb/tb_reduction_engine.sv
// tb_reduction_engine: scoreboard bench; expected results queued at stimulus, checked at output handshake
module tb_reduction_engine;
    import reduction_pkg::*;
    localparam int DEPTH = 4, DATA_W = 32, TAG_W = 8, CHILD_W = 3, ALU_LAT = 2, DST_W = 9;
    localparam logic [DST_W-1:0] RANK = 9'h1A5;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, err_op;
    logic [TAG_W-1:0] in_tag = '0, out_tag;
    logic [3:0] in_op = '0, out_op;
    logic [CHILD_W-1:0] in_children = '0;
    logic [DST_W-1:0] in_dst = '0, out_src, out_dst;
    logic [DATA_W-1:0] in_payload = '0, out_payload;
    logic [2:0] busy_count;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [3:0]        op;
        logic [DATA_W-1:0] pay;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int n_chk = 0, n_pass = 0;
    int w, n;
    logic er;
    logic [3:0] t_op [6] = '{OP_AND, OP_OR, OP_LAND, OP_LAND, OP_LOR, OP_ADD};
    logic [DATA_W-1:0] t_a [6] = '{32'hF0F0, 32'hF0F0, 32'h5, 32'h5, 32'h0, 32'hFFFF_FFFF};
    logic [DATA_W-1:0] t_b [6] = '{32'h0FF0, 32'h0FF0, 32'h0, 32'h8000_0000, 32'h0, 32'h2};

    reduction_engine #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .CHILD_W(CHILD_W),
                       .ALU_LAT(ALU_LAT), .DST_W(DST_W), .RANK(RANK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_op(in_op), .in_children(in_children), .in_dst(in_dst), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_op(out_op),
        .out_src(out_src), .out_dst(out_dst), .out_payload(out_payload), .err_op(err_op),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [DST_W-1:0] dst_of(input logic [TAG_W-1:0] tag);
        return {1'b1, tag};
    endfunction

    function automatic logic [DATA_W-1:0] model(input logic [3:0] op, input logic [DATA_W-1:0] a, b);
        case (op)
            OP_ADD:  return a + b;
            OP_MAX:  return $signed(a) > $signed(b) ? a : b;
            OP_MIN:  return $signed(a) < $signed(b) ? a : b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_LAND: return {31'b0, (a != 0) && (b != 0)};
            OP_LOR:  return {31'b0, (a != 0) || (b != 0)};
            default: return a;
        endcase
    endfunction

    task automatic push(input logic [TAG_W-1:0] tag, input logic [3:0] op, input logic [DATA_W-1:0] pay);
        exp_q.push_back('{tag, op, pay});
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TAG_W-1:0] tag, input logic [3:0] op, input logic [CHILD_W-1:0] ch,
                        input logic [DATA_W-1:0] pay, output int waits, output logic err);
        in_valid = 1'b1;
        in_tag = tag;
        in_op = op;
        in_children = ch;
        in_dst = dst_of(tag);
        in_payload = pay;
        waits = 0;
        err = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                err = err_op;
                break;
            end
            waits++;
            if (waits > 50) begin
                check("send_timeout", waits, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (out_valid) break;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("out_expected", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("out_tag", out_tag, e.tag);
                check("out_op", out_op, e.op);
                check("out_payload", out_payload, e.pay);
                check("out_src", out_src, RANK);
                check("out_dst", out_dst, dst_of(e.tag));
            end
        end
    end

    initial begin
        step(2);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy_count, 0);
        check("rst_err", err_op, 0);
        check("rst_payload", out_payload, 0);
        rst = 1'b0;
        #1 check("rdy_before_edge", in_ready, 0);
        step(1);
        check("rdy_after_edge", in_ready, 1);

        send(3, OP_ADD, 2, 5, w, er);
        send(3, OP_ADD, 0, 7, w, er);
        check("accum_no_stall", w, 0);
        push(3, OP_ADD, 21);
        send(3, OP_ADD, 0, 9, w, er);
        check("pend_stall", w, ALU_LAT);
        wait_valid(n);
        check("sum_latency", n, ALU_LAT + 1);
        step(1);

        push(1, OP_ADD, 32'hA5);
        send(1, OP_ADD, 0, 32'hA5, w, er);
        wait_valid(n);
        check("leaf_latency", n, 1);
        step(1);

        send(2, OP_MAX, 1, 32'hFFFF_FFFC, w, er);
        push(2, OP_MAX, 32'd3);
        send(2, OP_MAX, 0, 32'd3, w, er);
        wait_valid(n);
        step(1);
        send(2, OP_MIN, 1, 32'hFFFF_FFFC, w, er);
        push(2, OP_MIN, 32'hFFFF_FFFC);
        send(2, OP_MIN, 0, 32'd3, w, er);
        wait_valid(n);
        step(1);

        for (int i = 0; i < 6; i++) begin
            send(1, t_op[i], 1, t_a[i], w, er);
            push(1, t_op[i], model(t_op[i], t_a[i], t_b[i]));
            send(1, t_op[i], 0, t_b[i], w, er);
            wait_valid(n);
            step(1);
        end

        send(1, OP_ADD, 1, 10, w, er);
        push(1, OP_ADD, 14);
        send(1, OP_AND, 0, 4, w, er);
        check("mismatch_err", er, 1);
        wait_valid(n);
        step(1);

        send(3, 4'b1000, 1, 32'h33, w, er);
        push(3, 4'b1000, 32'h33);
        send(3, 4'b1000, 0, 32'h44, w, er);
        check("same_op_no_err", er, 0);
        repeat (ALU_LAT) @(negedge clk);
        check("wb_err", err_op, 1);
        wait_valid(n);
        check("unk_latency", n, 1);
        step(1);

        out_ready = 1'b0;
        push(0, OP_ADD, 11);
        push(2, OP_ADD, 22);
        send(0, OP_ADD, 0, 11, w, er);
        send(2, OP_ADD, 0, 22, w, er);
        @(negedge clk);
        check("busy_two", busy_count, 2);
        for (int i = 0; i < 5; i++) begin
            check("hold_tag", out_tag, 0);
            check("hold_payload", out_payload, 11);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_tag = 0;
        in_op = OP_ADD;
        @(negedge clk);
        check("done_block", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("busy_2", busy_count, 2);
        @(negedge clk);
        check("busy_1", busy_count, 1);
        check("second_tag", out_tag, 2);
        @(negedge clk);
        check("busy_0", busy_count, 0);
        step(1);

        out_ready = 1'b0;
        send(1, OP_ADD, 0, 7, w, er);
        send(2, OP_ADD, 2, 100, w, er);
        send(2, OP_ADD, 0, 50, w, er);
        check("pre_rst_busy", busy_count, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy_count, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_payload", out_payload, 0);
        out_ready = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        check("post_rst_ready", in_ready, 1);
        push(2, OP_ADD, 3);
        send(2, OP_ADD, 1, 1, w, er);
        send(2, OP_ADD, 0, 2, w, er);
        wait_valid(n);
        check("post_rst_latency", n, ALU_LAT + 1);
        step(3);
        check("busy_end", busy_count, 0);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/reduction_engine.md
REDUCTION_ENGINE -- requirements
Module: reduction_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning table entries (power of 2, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, meaning payload width.
REQ-003 SHALL have parameter TAG_W, default 8, meaning tag width; the low log2(DEPTH) bits select the entry.
REQ-004 SHALL have parameter CHILD_W, default 3, meaning contribution-count width.
REQ-005 SHALL have parameter ALU_LAT, default 2, meaning ALU pipeline depth (>=1).
REQ-006 SHALL have parameter DST_W, default 9, meaning destination width.
REQ-007 SHALL have parameter RANK, default 0, meaning own node id, DST_W bits.
REQ-008 SHALL have ports: clk in 1, clock; rst in 1, reset. One clock; reset is asynchronous and active-high.
REQ-009 SHALL have ports: in_valid in 1; in_ready out 1; in_tag in TAG_W; in_op in 4; in_children in CHILD_W, contributions still expected after this one; in_dst in DST_W; in_payload in DATA_W.
REQ-010 SHALL have ports: out_valid out 1; out_ready in 1; out_tag out TAG_W; out_op out 4; out_src out DST_W (=RANK); out_dst out DST_W; out_payload out DATA_W.
REQ-011 SHALL have ports: err_op out 1, one-cycle error pulse; busy_count out log2(DEPTH)+1, number of non-FREE entries.

Function
REQ-012 SHALL hold per entry: state FREE/ACCUM/DONE, tag, op, dst, remaining, accumulator.
REQ-013 SHALL accept a contribution only when in_valid && in_ready are both high at a clk edge.
REQ-014 SHALL drive in_ready low when the target entry is DONE, when the ALU pipeline holds an op for that entry, or when the target entry is ACCUM with a different stored tag; otherwise in_ready SHALL be high.
REQ-015 SHALL handle acceptance into a FREE entry by storing tag, op, dst, payload and remaining=in_children; the state SHALL become ACCUM, or DONE if in_children==0 (leaf).
REQ-016 SHALL handle acceptance into an ACCUM entry by issuing (accumulator, in_payload, stored op) to the ALU; the result SHALL be written back exactly ALU_LAT cycles later, with remaining decremented at writeback.
REQ-017 SHALL move the entry to DONE in the same writeback cycle that remaining reaches 0.
REQ-018 SHALL use op codes 1111 ADD, modulo 2^DATA_W; 0000 signed MAX; 0001 signed MIN; 0010 bitwise AND; 0011 bitwise OR; 0100 logical AND (result 0/1); 0101 logical OR (result 0/1).
REQ-019 SHALL, for an unknown stored op, leave the accumulator unchanged, still decrement remaining, and pulse err_op at writeback.
REQ-020 SHALL, when in_op differs from the stored op of an ACCUM entry, use the stored op and pulse err_op in the accept cycle.
REQ-021 SHALL assert out_valid whenever any entry is DONE, presenting the lowest-index DONE entry; fields SHALL stay stable while out_ready is low.
REQ-022 SHALL set the entry FREE on an out_valid && out_ready handshake; a new contribution to that entry SHALL be accepted no earlier than the next cycle.
REQ-023 SHALL allow an accept, a writeback and an output handshake on distinct entries in the same cycle, with all three taking effect.
REQ-024 SHALL give out_valid a minimum latency of 1 cycle from accept for a leaf, and ALU_LAT+1 cycles from the final accept otherwise.
REQ-025 SHALL keep busy_count equal to the count of ACCUM plus DONE entries, updated every cycle.

Reset
REQ-026 SHALL, on rst assertion, immediately set all entries FREE, flush the ALU pipeline, and drive in_ready=0, out_valid=0, err_op=0, busy_count=0 and all out_* data=0.
REQ-027 SHALL discard in-flight ALU results when rst is asserted mid-operation; in_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-028 SHALL place the op-code constants, the entry-state enum and the entry record type in shared package reduction_pkg.
REQ-029 SHALL implement the combine logic as sub-module reduce_alu, ALU_LAT-stage pipelined, carrying the entry index and a valid bit alongside the data.

Verification
REQ-030 SHALL cover: tag 3, op ADD, children 2, payloads 5, 7, 9 -> one output with payload 21, out_src=RANK, ALU_LAT+1 cycles after the last accept.
REQ-031 SHALL cover: tag 1, children 0, payload 0xA5 -> out_valid the next cycle with payload 0xA5.
REQ-032 SHALL cover: op MAX, children 1, payloads -4 then 3 -> payload 3; op MIN with the same inputs -> payload -4.
REQ-033 SHALL cover: tags 0 and 2 both DONE with out_ready held low 5 cycles -> tag 0 emitted first and held stable, then tag 2; busy_count goes 2 -> 1 -> 0.
REQ-034 SHALL cover: a second contribution to an entry whose op is in the ALU pipeline -> in_ready=0 until writeback; contribution to a DONE entry -> in_ready=0 until the handshake.
REQ-035 SHALL cover: rst asserted mid-accumulation -> out_valid=0 and busy_count=0 immediately; a fresh sum after release is correct with no stale data.
